sd_cmd_seq: RTL

- Command sequencer directly upstream of the SD command-line controller inside the SD reader.
- Drives that controller's start/precnt/cmd/arg/clkdiv inputs and consumes its busy/done/timeout/syntaxe/resparg outputs.
- Runs the SD initialisation sequence and records card type and RCA.
- Afterwards serves single-sector read requests by issuing CMD17, then waits for the data-line stage to report completion.

---
 rtl/sd_cmd_seq.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_seq.sv
// sd_cmd_seq: SD card command sequencer.
//
// Sits directly upstream of the SD command-line controller. After reset it
// walks the card through CMD0, CMD8, CMD55/ACMD41 (repeated until the card
// reports ready), CMD2, CMD3, CMD7 and CMD16 at the slow identification clock.
// It records the card type (CCS) and the RCA, then switches the controller to
// the fast divider. From then on it serves single-sector read requests by
// issuing CMD17 and waits for the data-line stage to finish the sector.
//
// Optional build macro:
//   SD_V1_FALLBACK_EN - a CMD8 timeout is treated as an SDv1 card (HCS=0 in
//                       ACMD41, card_sdhc forced to 0) instead of an error.
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   sdc_start          one-cycle command start pulse to the controller
//   sdc_precnt         idle sdclk cycles before the command
//   sdc_cmd, sdc_arg   command index and argument
//   sdc_clkdiv         sdclk divider
//   sdc_busy           controller busy
//   sdc_done           one-cycle command-finished pulse
//   sdc_timeout        no response (valid with sdc_done)
//   sdc_syntaxe        response format/index error (valid with sdc_done)
//   sdc_resparg        response argument field
//   rd_req, rd_sector  level read request (held until rd_ack) and sector number
//   rd_ack             one-cycle pulse: request accepted
//   rd_cmd_ok          one-cycle pulse: CMD17 response good
//   rd_err             one-cycle pulse: CMD17 failed
//   rd_data_done       data-line stage finished the sector
//   init_done          card ready
//   init_err           sticky initialisation failure
//   card_sdhc          CCS bit from ACMD41
//   card_rca           relative card address
module sd_cmd_seq #(
  parameter logic [15:0] SLOWDIV    = 16'd50,
  parameter logic [15:0] FASTDIV    = 16'd1,
  parameter logic [15:0] ACMD41_MAX = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        sdc_start,
  output logic [15:0] sdc_precnt,
  output logic [5:0]  sdc_cmd,
  output logic [31:0] sdc_arg,
  output logic [15:0] sdc_clkdiv,
  input  logic        sdc_busy,
  input  logic        sdc_done,
  input  logic        sdc_timeout,
  input  logic        sdc_syntaxe,
  input  logic [31:0] sdc_resparg,
  input  logic        rd_req,
  input  logic [31:0] rd_sector,
  output logic        rd_ack,
  output logic        rd_cmd_ok,
  output logic        rd_err,
  input  logic        rd_data_done,
  output logic        init_done,
  output logic        init_err,
  output logic        card_sdhc,
  output logic [15:0] card_rca
);

  typedef enum logic [3:0] {
    S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD2, S_CMD3, S_CMD7, S_CMD16,
    S_IDLE, S_CMD17, S_RD_WAIT, S_ERR
  } state_t;

  state_t      state_q;
  logic        issued_q;    // command of the current state has been started
  logic        card_v2_q;
  logic        slow55_q;    // next CMD55 follows a not-ready ACMD41
  logic [15:0] attempts_q;
  logic [31:0] sector_q;

  logic        is_cmd_d;
  logic [5:0]  cmd_d;
  logic [31:0] arg_d;
  logic [15:0] pre_d;
  logic [15:0] attempts_d;
  logic        done_d;

  // Response bits 15:12 carry no information this block acts on.
  logic unused_resp_bits;
  assign unused_resp_bits = ^sdc_resparg[15:12];

  // Command to issue in the current state.
  always_comb begin
    is_cmd_d = 1'b1;
    cmd_d    = 6'd0;
    arg_d    = 32'd0;
    pre_d    = 16'd2;
    case (state_q)
      S_CMD0:   pre_d = 16'd250;
      S_CMD8:   begin cmd_d = 6'd8;  arg_d = 32'h0000_01AA; end
      S_CMD55:  begin cmd_d = 6'd55; pre_d = slow55_q ? 16'd1000 : 16'd2; end
      S_ACMD41: begin
        cmd_d = 6'd41;
        arg_d = card_v2_q ? 32'h4010_0000 : 32'h0010_0000;
      end
      S_CMD2:   cmd_d = 6'd2;
      S_CMD3:   cmd_d = 6'd3;
      S_CMD7:   begin cmd_d = 6'd7;  arg_d = {card_rca, 16'h0000}; end
      S_CMD16:  begin cmd_d = 6'd16; arg_d = 32'd512; end
      // Standard-capacity cards take a byte address; it wraps modulo 2^32.
      S_CMD17:  begin
        cmd_d = 6'd17;
        arg_d = card_sdhc ? sector_q : {sector_q[22:0], 9'b0};
      end
      default:  is_cmd_d = 1'b0;
    endcase
  end

  assign attempts_d = attempts_q + 16'd1;
  // A done pulse counts only once our own start has gone out and retired.
  assign done_d     = is_cmd_d && issued_q && !sdc_start && sdc_done;
  // Accept is combinational so the sector is captured in the ack cycle.
  assign rd_ack     = (state_q == S_IDLE) && rd_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_CMD0;
      issued_q   <= 1'b0;
      card_v2_q  <= 1'b0;
      slow55_q   <= 1'b0;
      attempts_q <= 16'd0;
      sector_q   <= 32'd0;
      sdc_start  <= 1'b0;
      sdc_precnt <= 16'd0;
      sdc_cmd    <= 6'd0;
      sdc_arg    <= 32'd0;
      sdc_clkdiv <= SLOWDIV;
      rd_cmd_ok  <= 1'b0;
      rd_err     <= 1'b0;
      init_done  <= 1'b0;
      init_err   <= 1'b0;
      card_sdhc  <= 1'b0;
      card_rca   <= 16'd0;
    end else begin
      sdc_start <= 1'b0;
      rd_cmd_ok <= 1'b0;
      rd_err    <= 1'b0;
      if (is_cmd_d && !issued_q) begin
        if (!sdc_busy) begin
          sdc_start  <= 1'b1;
          sdc_cmd    <= cmd_d;
          sdc_arg    <= arg_d;
          sdc_precnt <= pre_d;
          issued_q   <= 1'b1;
        end
      end else if (done_d) begin
        issued_q <= 1'b0;
        case (state_q)
          S_CMD0: state_q <= S_CMD8;
          S_CMD8: begin
            if (!sdc_timeout && !sdc_syntaxe && sdc_resparg[11:0] == 12'h1AA) begin
              card_v2_q <= 1'b1;
              state_q   <= S_CMD55;
            end
`ifdef SD_V1_FALLBACK_EN
            else if (sdc_timeout) begin
              state_q <= S_CMD55;
            end
`endif
            else begin
              state_q  <= S_ERR;
              init_err <= 1'b1;
            end
          end
          S_CMD55: begin
            if (sdc_timeout || sdc_syntaxe) begin
              state_q  <= S_ERR;
              init_err <= 1'b1;
            end else begin
              state_q <= S_ACMD41;
            end
          end
          S_ACMD41: begin
            if (sdc_timeout) begin
              state_q  <= S_ERR;
              init_err <= 1'b1;
            end else if (sdc_resparg[31]) begin
`ifdef SD_V1_FALLBACK_EN
              card_sdhc <= sdc_resparg[30] & card_v2_q;
`else
              card_sdhc <= sdc_resparg[30];
`endif
              slow55_q <= 1'b0;
              state_q  <= S_CMD2;
            end else begin
              attempts_q <= attempts_d;
              if (attempts_d >= ACMD41_MAX) begin
                state_q  <= S_ERR;
                init_err <= 1'b1;
              end else begin
                slow55_q <= 1'b1;
                state_q  <= S_CMD55;
              end
            end
          end
          // R2 carries no index field, so a syntax flag here is meaningless.
          S_CMD2: begin
            if (sdc_timeout) begin
              state_q  <= S_ERR;
              init_err <= 1'b1;
            end else begin
              state_q <= S_CMD3;
            end
          end
          S_CMD3: begin
            card_rca <= sdc_resparg[31:16];
            if (sdc_timeout || sdc_syntaxe || sdc_resparg[31:16] == 16'd0) begin
              state_q  <= S_ERR;
              init_err <= 1'b1;
            end else begin
              state_q <= S_CMD7;
            end
          end
          S_CMD7: begin
            if (sdc_timeout || sdc_syntaxe) begin
              state_q  <= S_ERR;
              init_err <= 1'b1;
            end else begin
              state_q <= S_CMD16;
            end
          end
          // The controller is idle here, so the divider can switch safely.
          S_CMD16: begin
            if (sdc_timeout || sdc_syntaxe) begin
              state_q  <= S_ERR;
              init_err <= 1'b1;
            end else begin
              sdc_clkdiv <= FASTDIV;
              init_done  <= 1'b1;
              state_q    <= S_IDLE;
            end
          end
          S_CMD17: begin
            if (!sdc_timeout && !sdc_syntaxe && sdc_resparg[31:19] == 13'd0) begin
              rd_cmd_ok <= 1'b1;
              state_q   <= S_RD_WAIT;
            end else begin
              rd_err  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
          default: state_q <= state_q;
        endcase
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rd_req) begin
              sector_q <= rd_sector;
              state_q  <= S_CMD17;
            end
          end
          S_RD_WAIT: begin
            if (rd_data_done) state_q <= S_IDLE;
          end
          S_ERR: begin
            init_err  <= 1'b1;
            init_done <= 1'b0;
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

endmodule
